// File: rtl/vertical_skew_feeder_if.sv
// rtl/vertical_skew_feeder_if.sv - row input stream and per-column FIFO write port
interface vertical_skew_feeder_if #(
   parameter int DATA_W = 8,
   parameter int COLS   = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_row [COLS-1:0];
   logic [COLS-1:0]   fifo_WREADY_col;
   logic [COLS-1:0]   fifo_WVALID_col;
   logic [DATA_W-1:0] out_col [COLS-1:0];

   modport master (
      output in_valid, in_row, fifo_WREADY_col,
      input  in_ready, fifo_WVALID_col, out_col
   );

   modport slave (
      input  in_valid, in_row, fifo_WREADY_col,
      output in_ready, fifo_WVALID_col, out_col
   );
endinterface

// File: rtl/vertical_skew_feeder.sv
// rtl/vertical_skew_feeder.sv - skews tile rows into per-column FIFOs for a systolic array
// Column j sees row data j+1 advances after acceptance; every line stalls together.
module vertical_skew_feeder #(
   parameter int DATA_W = 8,
   parameter int COLS   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            cfg_rows,
   vertical_skew_feeder_if.slave bus,
   output logic                  busy,
   output logic                  tile_done
);
   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t          state;
   logic [7:0]      rows_q;
   logic [7:0]      row_cnt;
   logic [4:0]      drain_cnt;
   logic [COLS-1:0] last_valid;
   logic            advance;
   logic            load;

   // A single stalled column freezes all lines so the diagonal skew never breaks.
   assign advance             = &(~last_valid | bus.fifo_WREADY_col);
   assign bus.in_ready        = (state == FEED) && advance;
   assign load                = bus.in_valid && bus.in_ready;
   assign bus.fifo_WVALID_col = last_valid & {COLS{advance}};
   assign busy                = (state == FEED) || (state == DRAIN);
   assign tile_done           = (state == DONE);

   for (genvar j = 0; j < COLS; j++) begin : g_col
      logic [DATA_W-1:0] dat [0:j];
      logic [j:0]        vld;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int k = 0; k <= j; k++) dat[k] <= '0;
            vld <= '0;
         end else if (advance) begin
            for (int k = j; k > 0; k--) begin
               dat[k] <= dat[k-1];
               vld[k] <= vld[k-1];
            end
            dat[0] <= load ? bus.in_row[j] : '0;
            vld[0] <= load;
         end
      end

      assign last_valid[j] = vld[j];
      assign bus.out_col[j] = dat[j];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rows_q    <= '0;
         row_cnt   <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  rows_q  <= cfg_rows;
                  row_cnt <= '0;
                  state   <= (cfg_rows == 8'd0) ? DONE : FEED;
               end
            end
            FEED: begin
               if (load) begin
                  row_cnt <= row_cnt + 8'd1;
                  if (row_cnt == rows_q - 8'd1) begin
                     state     <= DRAIN;
                     drain_cnt <= '0;
                  end
               end
            end
            DRAIN: begin
               // COLS advances flush the deepest line after the last row.
               if (advance) begin
                  drain_cnt <= drain_cnt + 5'd1;
                  if (drain_cnt == 5'(COLS - 1)) state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vertical_skew_feeder.sv
// tb/tb_vertical_skew_feeder.sv - directed bench with a row/advance-count reference model
module tb_vertical_skew_feeder;
   localparam int DW = 8;
   localparam int NC = 16;
   localparam int P_IDLE = 0, P_FEED = 1, P_DRAIN = 2, P_DONE = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] cfg_rows = 8'd0;
   logic       busy;
   logic       tile_done;

   vertical_skew_feeder_if #(.DATA_W(DW), .COLS(NC)) bus ();

   vertical_skew_feeder #(.DATA_W(DW), .COLS(NC)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cfg_rows  (cfg_rows),
      .bus       (bus),
      .busy      (busy),
      .tile_done (tile_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // reference model: accepted rows tagged with the advance count at acceptance
   logic [NC*DW-1:0] rq_d [$];
   int               rq_a [$];
   int ph = P_IDLE;
   int rows_left = 0;
   int drain_left = 0;
   int adv_n = 0;

   // observations of the DUT for the per-tile literal checks
   int wr_cnt = 0;
   int first_wr [NC];
   int acc_cyc = -1;
   int done_cyc = -1;
   int done_cnt = 0;
   bit busy_seen = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [NC*DW-1:0] mk_row(input int base);
      logic [NC*DW-1:0] r;
      for (int j = 0; j < NC; j++) r[j*DW +: DW] = 8'(base + j * 7);
      return r;
   endfunction

   function automatic logic [NC*DW-1:0] pack_out();
      logic [NC*DW-1:0] r;
      for (int j = 0; j < NC; j++) r[j*DW +: DW] = bus.out_col[j];
      return r;
   endfunction

   function automatic logic [NC*DW-1:0] pack_in();
      logic [NC*DW-1:0] r;
      for (int j = 0; j < NC; j++) r[j*DW +: DW] = bus.in_row[j];
      return r;
   endfunction

   always @(negedge clk) begin : cmp
      logic [NC-1:0]    lv;
      logic [NC*DW-1:0] ld;
      logic [NC-1:0]    ewv;
      logic             madv;
      logic             ery;
      bit               acc;
      int               k;
      if (!rst) begin
         chk("rst_wvalid", bus.fifo_WVALID_col, '0);
         chk("rst_in_ready", bus.in_ready, 1'b0);
         chk("rst_busy", busy, 1'b0);
         chk("rst_tile_done", tile_done, 1'b0);
         chk("rst_out_col", pack_out(), '0);
         rq_d.delete();
         rq_a.delete();
         ph = P_IDLE;
         adv_n = 0;
      end else begin
         lv = '0;
         ld = '0;
         foreach (rq_a[i]) begin
            k = adv_n - rq_a[i] - 1;
            if (k >= 0 && k < NC) begin
               lv[k] = 1'b1;
               ld[k*DW +: DW] = rq_d[i][k*DW +: DW];
            end
         end
         madv = &(~lv | bus.fifo_WREADY_col);
         ewv  = lv & {NC{madv}};
         ery  = (ph == P_FEED) && madv;
         chk("wvalid", bus.fifo_WVALID_col, ewv);
         chk("in_ready", bus.in_ready, ery);
         chk("busy", busy, (ph == P_FEED) || (ph == P_DRAIN));
         chk("tile_done", tile_done, ph == P_DONE);
         for (int j = 0; j < NC; j++)
            if (ewv[j] && bus.fifo_WVALID_col[j])
               chk($sformatf("col%0d_data", j), bus.out_col[j], ld[j*DW +: DW]);

         wr_cnt += $countones(bus.fifo_WVALID_col);
         for (int j = 0; j < NC; j++)
            if (bus.fifo_WVALID_col[j] && first_wr[j] < 0) first_wr[j] = cyc;
         if (bus.in_valid && bus.in_ready && acc_cyc < 0) acc_cyc = cyc;
         if (tile_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (busy) busy_seen = 1;

         acc = bus.in_valid && ery;
         if (madv) begin
            if (acc) begin
               rq_d.push_back(pack_in());
               rq_a.push_back(adv_n);
            end
            adv_n++;
            while (rq_a.size() > 0 && adv_n - rq_a[0] - 1 >= NC) begin
               void'(rq_d.pop_front());
               void'(rq_a.pop_front());
            end
         end
         case (ph)
            P_IDLE: if (start) begin
               rows_left = int'(cfg_rows);
               ph = (cfg_rows == 8'd0) ? P_DONE : P_FEED;
            end
            P_FEED: if (acc) begin
               rows_left--;
               if (rows_left == 0) begin
                  ph = P_DRAIN;
                  drain_left = NC;
               end
            end
            P_DRAIN: if (madv) begin
               drain_left--;
               if (drain_left == 0) ph = P_DONE;
            end
            default: ph = P_IDLE;
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic new_tile();
      wr_cnt = 0;
      foreach (first_wr[j]) first_wr[j] = -1;
      acc_cyc = -1;
      done_cyc = -1;
      done_cnt = 0;
      busy_seen = 0;
   endtask

   task automatic do_start(input logic [7:0] rows);
      start = 1'b1;
      cfg_rows = rows;
      step();
      start = 1'b0;
      cfg_rows = 8'hA5;
   endtask

   task automatic feed_row(input logic [NC*DW-1:0] r);
      int n = 0;
      bit ok = 0;
      bus.in_valid = 1'b1;
      for (int j = 0; j < NC; j++) bus.in_row[j] = r[j*DW +: DW];
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = bus.in_ready;
         step();
         n++;
      end
      chk("feed_accept_timeout", ok, 1'b1);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (done_cnt == 0 && n < 300) begin
         step();
         n++;
      end
      chk({nm, "_done_timeout"}, done_cnt != 0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0;
      for (int j = 0; j < NC; j++) bus.in_row[j] = '0;
      bus.fifo_WREADY_col = '1;
      foreach (first_wr[j]) first_wr[j] = -1;
      repeat (3) step();
      chk("reset_in_ready", bus.in_ready, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_wvalid", bus.fifo_WVALID_col, '0);
      rst = 1'b1;
      step();

      // three rows back-to-back, no backpressure
      new_tile();
      do_start(8'd3);
      feed_row(mk_row(8'h10));
      feed_row(mk_row(8'h40));
      feed_row(mk_row(8'h80));
      wait_done("t1");
      chk("t1_writes", wr_cnt, 48);
      chk("t1_done_lat", done_cyc - acc_cyc, 19);
      chk("t1_col0_lat", first_wr[0] - acc_cyc, 1);
      chk("t1_col15_lat", first_wr[15] - acc_cyc, 16);
      step();

      // column 7 stalls for five cycles while holding row B
      new_tile();
      do_start(8'd3);
      fork
         begin
            feed_row(mk_row(8'h21));
            feed_row(mk_row(8'h52));
            feed_row(mk_row(8'h93));
         end
         begin
            int n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!bus.fifo_WVALID_col[7] && n < 100);
            chk("t2_col7_seen", bus.fifo_WVALID_col[7], 1'b1);
            step();
            bus.fifo_WREADY_col[7] = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            bus.fifo_WREADY_col[7] = 1'b1;
         end
      join
      wait_done("t2");
      chk("t2_writes", wr_cnt, 48);
      chk("t2_done_lat", done_cyc - acc_cyc, 24);
      step();

      // four rows with a two-cycle input gap after row 1
      new_tile();
      do_start(8'd4);
      feed_row(mk_row(8'h05));
      feed_row(mk_row(8'h33));
      step();
      step();
      feed_row(mk_row(8'h66));
      feed_row(mk_row(8'hC9));
      wait_done("t3");
      chk("t3_writes", wr_cnt, 64);
      chk("t3_done_lat", done_cyc - acc_cyc, 22);
      step();

      // empty tile
      new_tile();
      do_start(8'd0);
      wait_done("t4");
      chk("t4_writes", wr_cnt, 0);
      chk("t4_busy_seen", busy_seen, 1'b0);
      step();

      // start pulsed during FEED must be ignored
      new_tile();
      do_start(8'd3);
      feed_row(mk_row(8'h17));
      start = 1'b1;
      cfg_rows = 8'd1;
      step();
      start = 1'b0;
      feed_row(mk_row(8'h71));
      feed_row(mk_row(8'hE2));
      wait_done("t5");
      chk("t5_writes", wr_cnt, 48);
      chk("t5_done_lat", done_cyc - acc_cyc, 20);
      step();

      // asynchronous reset with rows in flight
      new_tile();
      do_start(8'd5);
      feed_row(mk_row(8'h2B));
      feed_row(mk_row(8'h4D));
      feed_row(mk_row(8'h6F));
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("t6_async_out_col", pack_out(), '0);
      chk("t6_async_wvalid", bus.fifo_WVALID_col, '0);
      chk("t6_async_busy", busy, 1'b0);
      chk("t6_async_in_ready", bus.in_ready, 1'b0);
      repeat (2) step();
      rst = 1'b1;
      new_tile();
      repeat (25) step();
      chk("t6_writes_after_rst", wr_cnt, 0);
      chk("t6_busy_after_rst", busy_seen, 1'b0);

      // recovery tile
      new_tile();
      do_start(8'd2);
      feed_row(mk_row(8'h90));
      feed_row(mk_row(8'hF1));
      wait_done("t7");
      chk("t7_writes", wr_cnt, 32);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
